m_debounce_edge: RTL
====================

// Module: m_debounce_edge
// PURPOSE
//  Consumes the single-bit level from a multi-flop synchronizer chain and debounces it.
//  Produces a filtered stable level, single-cycle rise/fall pulses and a wrapping event count.
//  i_data must already be synchronous to clk; this block adds no metastability protection.
//  Sits between the sync chain and control logic (buttons, external status pins, slow handshake lines).
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive differing samples required to accept a new level; legal range >=1
//  CNT_W            8   width of o_evt_cnt (and o_glitch_cnt when the optional feature is enabled)
//  RST_LEVEL        0   value loaded into o_level on reset
// PORTS
//  clk           in   1      clock; all logic is on the rising edge
//  rst           in   1      synchronous active-high reset
//  i_data        in   1      synchronized input level (synchronizer o_data)
//  i_clr         in   1      synchronous clear of the event and glitch counters
//  o_level       out  1      debounced level
//  o_rise        out  1      1-cycle pulse in the cycle o_level goes 0->1
//  o_fall        out  1      1-cycle pulse in the cycle o_level goes 1->0
//  o_busy        out  1      high while a candidate transition is being qualified (CHK_* states)
//  o_evt_cnt     out  CNT_W  count of accepted transitions (rise+fall), wraps modulo 2^CNT_W
//  o_glitch_cnt  out  CNT_W  rejected candidates; present only with DEBOUNCE_GLITCH_CNT_EN
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=RST_LEVEL ? STABLE_HI : STABLE_LO; o_level=RST_LEVEL.
//    o_rise, o_fall, o_busy, o_evt_cnt and o_glitch_cnt are all 0. rst overrides every other input.
//  - All outputs are registered. Qualify counter width is $clog2(DEBOUNCE_CYCLES+1).
//  - FSM states: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
//    STABLE_LO: i_data=1 -> CHK_HI, qcnt=1. If DEBOUNCE_CYCLES==1, go directly to STABLE_HI and accept.
//    CHK_HI: i_data=1 -> qcnt++. When qcnt reaches DEBOUNCE_CYCLES -> STABLE_HI and accept.
//            i_data=0 -> STABLE_LO, qcnt=0; this is a glitch.
//    STABLE_HI and CHK_LO mirror STABLE_LO and CHK_HI with polarity inverted.
//  - Accept means: o_level toggles, o_rise or o_fall =1 for exactly that one cycle, o_evt_cnt++.
//  - Latency: if i_data goes high and stays high, o_level rises on the DEBOUNCE_CYCLES-th sampling edge.
//    The first sampling edge is the one that sees i_data=1.
//  - Every candidate that does not reach DEBOUNCE_CYCLES is rejected. A rejected candidate never
//    changes o_level and never produces a pulse.
//  - o_busy = 1 exactly while in CHK_HI or CHK_LO.
//  - Counter wrap: o_evt_cnt = 2^CNT_W-1 plus an accept gives 0; there is no saturation.
//  - i_clr with no event in the same cycle: counters become 0.
//    i_clr in the same cycle as an accept (or a glitch, for the glitch counter): that counter becomes 1.
//  - i_clr does not affect the FSM, o_level or the pulse outputs.
//  - rst asserted mid-qualification: the candidate is discarded and not counted as a glitch.
//  - o_rise and o_fall are never high in the same cycle. The minimum spacing between accepts is DEBOUNCE_CYCLES cycles.
// CONFIGURATION
//  DEBOUNCE_GLITCH_CNT_EN defined:
//    o_glitch_cnt port exists. It increments once per rejected candidate (CHK_* -> STABLE_* without accept).
//    Wrap and i_clr rules match o_evt_cnt.
//  DEBOUNCE_GLITCH_CNT_EN undefined:
//    o_glitch_cnt port and its logic are absent. All other behaviour is identical.
// TESTING  (DEBOUNCE_CYCLES=4, CNT_W=8, RST_LEVEL=0 unless stated)
//  1. Hold rst=1 for 2 cycles with i_data=1.
//     -> o_level=0, o_evt_cnt=0, no pulses. After release, o_level=1 at the 4th edge and o_rise=1 for 1 cycle.
//  2. Drive i_data high for 3 cycles, then low.
//     -> o_level stays 0, o_busy=1 for 3 cycles, o_evt_cnt=0. With the macro defined, o_glitch_cnt=1.
//  3. Drive 0->1 held 10 cycles, then 1->0 held 10 cycles.
//     -> o_rise, then o_fall 10 cycles later, each 1 cycle wide; o_evt_cnt=2.
//  4. Preload via 255 accepted transitions, then one more.
//     -> o_evt_cnt goes 255 -> 0. i_clr in the cycle of the next accept -> o_evt_cnt=1.
//  5. Assert rst in the 2nd qualify cycle of CHK_HI.
//     -> o_level=0, o_busy=0, no pulse, o_glitch_cnt unchanged (0).
//  6. Run with DEBOUNCE_CYCLES=1 and RST_LEVEL=1.
//     -> reset gives o_level=1; i_data=0 gives o_fall one edge later; o_busy never asserts.

Source files
------------

// File: rtl/m_debounce_edge_if.sv
// Level/pulse/counter bundle between the debouncer and its consumer.
// Carries o_glitch_cnt only when DEBOUNCE_GLITCH_CNT_EN is defined.
interface m_debounce_edge_if #(
   parameter int CNT_W = 8
);
   logic             i_data;
   logic             i_clr;
   logic             o_level;
   logic             o_rise;
   logic             o_fall;
   logic             o_busy;
   logic [CNT_W-1:0] o_evt_cnt;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [CNT_W-1:0] o_glitch_cnt;

   modport master (output i_data, i_clr,
                   input  o_level, o_rise, o_fall, o_busy, o_evt_cnt, o_glitch_cnt);
   modport slave  (input  i_data, i_clr,
                   output o_level, o_rise, o_fall, o_busy, o_evt_cnt, o_glitch_cnt);
`else
   modport master (output i_data, i_clr,
                   input  o_level, o_rise, o_fall, o_busy, o_evt_cnt);
   modport slave  (input  i_data, i_clr,
                   output o_level, o_rise, o_fall, o_busy, o_evt_cnt);
`endif
endinterface

// File: rtl/m_debounce_edge.sv
// Debounces an already-synchronized level: stable level, rise/fall pulses, event counter.
// DEBOUNCE_GLITCH_CNT_EN adds a counter of rejected candidates.
module m_debounce_edge #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 8,
   parameter bit RST_LEVEL       = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   m_debounce_edge_if.slave   bus
);
   localparam int            QW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [QW-1:0] QMAX = QW'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_e;

   state_e           state_q, state_d;
   logic [QW-1:0]    qcnt_q, qcnt_d;
   logic             accept;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] evt_q, evt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RST_LEVEL ? STABLE_HI : STABLE_LO;
         qcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         qcnt_q  <= qcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      qcnt_d  = qcnt_q;
      accept  = 1'b0;
      case (state_q)
         STABLE_LO: if (bus.i_data) begin
            if (DEBOUNCE_CYCLES == 1) begin
               state_d = STABLE_HI;
               accept  = 1'b1;
            end else begin
               state_d = CHK_HI;
               qcnt_d  = QW'(1);
            end
         end
         CHK_HI: if (bus.i_data) begin
            if (qcnt_q + QW'(1) == QMAX) begin
               state_d = STABLE_HI;
               qcnt_d  = '0;
               accept  = 1'b1;
            end else begin
               qcnt_d  = qcnt_q + QW'(1);
            end
         end else begin
            state_d = STABLE_LO;
            qcnt_d  = '0;
         end
         STABLE_HI: if (!bus.i_data) begin
            if (DEBOUNCE_CYCLES == 1) begin
               state_d = STABLE_LO;
               accept  = 1'b1;
            end else begin
               state_d = CHK_LO;
               qcnt_d  = QW'(1);
            end
         end
         CHK_LO: if (!bus.i_data) begin
            if (qcnt_q + QW'(1) == QMAX) begin
               state_d = STABLE_LO;
               qcnt_d  = '0;
               accept  = 1'b1;
            end else begin
               qcnt_d  = qcnt_q + QW'(1);
            end
         end else begin
            state_d = STABLE_HI;
            qcnt_d  = '0;
         end
         default: begin
            state_d = STABLE_LO;
            qcnt_d  = '0;
         end
      endcase
   end

   // Outputs are computed from the transition and registered, so they line up with state_q.
   always_comb begin
      level_d = level_q ^ accept;
      rise_d  = accept & ~level_q;
      fall_d  = accept & level_q;
      busy_d  = (state_d == CHK_HI) || (state_d == CHK_LO);
      evt_d   = bus.i_clr ? CNT_W'(accept) : evt_q + CNT_W'(accept);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= RST_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
         evt_q   <= '0;
      end else begin
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
         evt_q   <= evt_d;
      end
   end

   assign bus.o_level   = level_q;
   assign bus.o_rise    = rise_q;
   assign bus.o_fall    = fall_q;
   assign bus.o_busy    = busy_q;
   assign bus.o_evt_cnt = evt_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic             glitch;
   logic [CNT_W-1:0] glitch_q, glitch_d;

   // A candidate is rejected when qualification drops back to the stable state it came from.
   assign glitch   = ((state_q == CHK_HI) && !bus.i_data) || ((state_q == CHK_LO) && bus.i_data);
   assign glitch_d = bus.i_clr ? CNT_W'(glitch) : glitch_q + CNT_W'(glitch);

   always_ff @(posedge clk) begin
      if (rst) glitch_q <= '0;
      else     glitch_q <= glitch_d;
   end

   assign bus.o_glitch_cnt = glitch_q;
`endif
endmodule
